hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It drives the PC write enable, the IF_ID register enable and flush, and the ID_EX bubble insert. It sequences three cases: load-use stalls of configurable length, multi-cycle flushes after a control-flow redirect, and external front-end freezes. It sits between the ID-stage decode/branch logic and the PC, IF_ID and ID_EX registers, and keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_controller.sv | 138 +++++++++++++
 tb/tb_hazard_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, post-redirect flushes, external front-end freeze.
// Latency: control outputs are combinational (zero-cycle response); counters visible one cycle later.
// Backpressure: ext_stall_req freezes PC/IF_ID with no bubbles and holds the sequencer state.
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             redirect,
  input  logic             ext_stall_req,
  output logic             pc_write,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The first hazard cycle is spent in RUN, so the sequencer covers the remainder.
  localparam logic [3:0] LOAD_INIT  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state = state_q;

  // Next-state and control outputs; priority is reset, then freeze, then state behaviour.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_enable = 1'b0;
      state_d      = RUN;
      cnt_d        = 4'd0;
    end else if (ext_stall_req) begin
      pc_write     = 1'b0;
      if_id_enable = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            // Redirect is ignored here: the branch stays in ID and is re-evaluated later.
            pc_write     = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = LOAD_INIT;
            end
          end else if (redirect) begin
            if_id_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end
        end
        FLUSH: begin
          // ID contents are being discarded, so hazards seen here are meaningless.
          if_id_flush = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign stall_inc = !reset && !pc_write && (stall_count != {CNT_W{1'b1}});
  assign flush_inc = if_id_flush && (flush_count != {CNT_W{1'b1}});

  // State register and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, redirect, ext_stall_req;
  logic       pc_write, if_id_enable, if_id_flush, id_ex_flush;
  logic [1:0] state;
  logic [3:0] stall_count, flush_count;
  logic [3:0] ctl;

  int checks = 0;
  int errors = 0;

  // {pc_write, if_id_enable, if_id_flush, id_ex_flush}
  assign ctl = {pc_write, if_id_enable, if_id_flush, id_ex_flush};

  hazard_controller #(
    .LOAD_STALL_CYCLES(2),
    .FLUSH_CYCLES(3),
    .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .redirect(redirect), .ext_stall_req(ext_stall_req),
    .pc_write(pc_write), .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    redirect = 1'b0; ext_stall_req = 1'b0;
  endtask

  // Leaves the bench at a falling edge in the first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_ctl_c1 got %b exp %b", ctl, 4'b0000); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_ctl_c2 got %b exp %b", ctl, 4'b0000); end
    @(negedge clk);
    reset = 1'b0; clear_inputs();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_count); end
    checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL rst_flush_cnt got %0d exp 0", flush_count); end
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL rst_free_ctl got %b exp %b", ctl, 4'b1100); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL lu_ctl_c1 got %b exp %b", ctl, 4'b0001); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL lu_state_c1 got %0d exp 0", state); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL lu_ctl_c2 got %b exp %b", ctl, 4'b0001); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lu_state_c2 got %0d exp 1", state); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL lu_ctl_c3 got %b exp %b", ctl, 4'b1100); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL lu_state_c3 got %0d exp 0", state); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 2", stall_count); end
    // A load into $zero never creates a hazard.
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL lu_zero_ctl got %b exp %b", ctl, 4'b1100); end
    // rt match only counts when the ID instruction actually reads rt.
    @(negedge clk);
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL lu_rt_unused_ctl got %b exp %b", ctl, 4'b1100); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_zero_cnt got %0d exp 2", stall_count); end
    id_uses_rt = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL lu_rt_used_ctl got %b exp %b", ctl, 4'b0001); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk); #1;
    checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL lu_rt_cnt got %0d exp 4", stall_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    redirect = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL rd_ctl_c1 got %b exp %b", ctl, 4'b1110); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rd_state_c1 got %0d exp 0", state); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL rd_ctl_c2 got %b exp %b", ctl, 4'b1110); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rd_state_c2 got %0d exp 2", state); end
    @(negedge clk);
    redirect = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL rd_ctl_c3 got %b exp %b", ctl, 4'b1110); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rd_state_c3 got %0d exp 2", state); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL rd_ctl_c4 got %b exp %b", ctl, 4'b1100); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rd_state_c4 got %0d exp 0", state); end
    checks++; if (flush_count !== 4'd3) begin errors++; $display("FAIL rd_flush_cnt got %0d exp 3", flush_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; redirect = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL sim_ctl got %b exp %b", ctl, 4'b0001); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sim_state got %0d exp 1", state); end
    @(negedge clk); #1;
    checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL sim_flush_cnt got %0d exp 0", flush_count); end
  endtask

  task automatic test_ext_freeze();
    do_reset();
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0; ext_stall_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL frz_ctl_%0d got %b exp %b", i, ctl, 4'b0000); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL frz_state_%0d got %0d exp 2", i, state); end
    end
    @(negedge clk);
    ext_stall_req = 1'b0;
    #1;
    checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL frz_stall_cnt got %0d exp 4", stall_count); end
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL frz_rem1_ctl got %b exp %b", ctl, 4'b1110); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL frz_rem2_ctl got %b exp %b", ctl, 4'b1110); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL frz_rem2_state got %0d exp 2", state); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL frz_done_ctl got %b exp %b", ctl, 4'b1100); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL frz_done_state got %0d exp 0", state); end
    checks++; if (flush_count !== 4'd3) begin errors++; $display("FAIL frz_flush_cnt got %0d exp 3", flush_count); end
  endtask

  task automatic test_saturation_abort();
    do_reset();
    ext_stall_req = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    checks++; if (stall_count !== 4'd14) begin errors++; $display("FAIL sat_cnt14 got %0d exp 14", stall_count); end
    repeat (6) @(negedge clk);
    ext_stall_req = 1'b0;
    #1;
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_cnt20 got %0d exp 15", stall_count); end
    // Abort a stall sequence with reset.
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    @(negedge clk);
    #1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_pre_state got %0d exp 1", state); end
    reset = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL abort_rst_ctl got %b exp %b", ctl, 4'b0000); end
    @(negedge clk);
    reset = 1'b0; clear_inputs();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL abort_stall_cnt got %0d exp 0", stall_count); end
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL abort_ctl got %b exp %b", ctl, 4'b1100); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_redirect();
    test_simultaneous();
    test_ext_freeze();
    test_saturation_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
